// File: rtl/mult_control.sv
// Shift-and-add multiplier sequencer: drives ACC Load/Sh/Ad from the ACC LSB.
// Define MULT_CTRL_ABORT_EN to add a synchronous Abort input.
module mult_control #(
  parameter int N = 4
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic St,
  input  logic M,
`ifdef MULT_CTRL_ABORT_EN
  input  logic Abort,
`endif
  output logic Load,
  output logic Sh,
  output logic Ad,
  output logic Done,
  output logic Busy
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] BIT   = 3'd2;
  localparam logic [2:0] SHIFT = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]    state, nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          abort;
  logic          last;

  assign Busy = (state == LOAD) ||
                (state == BIT)  ||
                (state == SHIFT);
  assign Done = (state == DONE);
  assign last = (cnt == LAST);

`ifdef MULT_CTRL_ABORT_EN
  assign abort = Abort & Busy;
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    nxt     = state;
    cnt_nxt = cnt;
    Load    = 1'b0;
    Sh      = 1'b0;
    Ad      = 1'b0;
    unique case (state)
      IDLE: if (St) nxt = LOAD;
      LOAD: begin
        Load    = 1'b1;
        cnt_nxt = '0;
        nxt     = BIT;
      end
      BIT: begin
        Ad = M;
        Sh = ~M;
        if (M)         nxt = SHIFT;
        else if (last) nxt = DONE;
        else           cnt_nxt = cnt + 1'b1;
      end
      SHIFT: begin
        Sh = 1'b1;
        if (last) nxt = DONE;
        else begin
          cnt_nxt = cnt + 1'b1;
          nxt     = BIT;
        end
      end
      DONE: if (!St) nxt = IDLE;
      default: nxt = IDLE;
    endcase
    // Abort wins over everything and silences the strobes this cycle
    if (abort) begin
      nxt  = IDLE;
      Load = 1'b0;
      Sh   = 1'b0;
      Ad   = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_mult_control.sv
// Bench for mult_control: closed loop with a behavioural ACC datapath,
// per-cycle strobe scoreboard, reset, handshake and optional abort.
module tb_mult_control;

  localparam int N = 4;
  localparam int W = 2 * N + 1;

  localparam logic [4:0] V_IDLE = 5'b00000;
  localparam logic [4:0] V_LOAD = 5'b10010;
  localparam logic [4:0] V_SH   = 5'b01010;
  localparam logic [4:0] V_AD   = 5'b00110;
  localparam logic [4:0] V_DONE = 5'b00001;

  logic Clk = 1'b0;
  logic Rst_n, St, M;
  logic Load, Sh, Ad, Done, Busy;
`ifdef MULT_CTRL_ABORT_EN
  logic Abort = 1'b0;
`endif

  logic [W-1:0] acc;
  logic [N-1:0] mplier, mcand;
  logic [4:0]   expq[$];
  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;

  mult_control #(.N(N)) dut (
    .Clk(Clk),
    .Rst_n(Rst_n),
    .St(St),
    .M(M),
`ifdef MULT_CTRL_ABORT_EN
    .Abort(Abort),
`endif
    .Load(Load),
    .Sh(Sh),
    .Ad(Ad),
    .Done(Done),
    .Busy(Busy)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // ACC datapath driven by the controller's strobes
  always @(posedge Clk) begin
    if (Load)
      acc <= {{(N+1){1'b0}}, mplier};
    else if (Ad)
      acc[2*N:N] <= {1'b0, acc[2*N-1:N]} + {1'b0, mcand};
    else if (Sh)
      acc <= acc >> 1;
  end
  assign M = acc[0];

  function automatic logic [4:0] outs();
    return {Load, Sh, Ad, Busy, Done};
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input logic [N-1:0] a,
                        input logic [N-1:0] b);
    int t0;
    int ones;
    int lat;
    logic [4:0] e;
    mcand  = a;
    mplier = b;
    ones   = 0;
    expq.push_back(V_LOAD);
    for (int i = 0; i < N; i++) begin
      if (b[i]) begin
        expq.push_back(V_AD);
        ones++;
      end
      expq.push_back(V_SH);
    end
    expq.push_back(V_DONE);
    @(negedge Clk);
    St = 1'b1;
    @(negedge Clk);
    t0 = cyc;
    e = expq.pop_front();
    chk($sformatf("load %0dx%0d", a, b), outs(), e);
    lat = 0;
    while (expq.size() > 0) begin
      @(negedge Clk);
      e = expq.pop_front();
      chk($sformatf("seq %0dx%0d", a, b), outs(), e);
      if (Done && lat == 0) lat = cyc - t0;
    end
    chk($sformatf("lat %0dx%0d", a, b), lat, 1 + N + ones);
    chk($sformatf("prod %0dx%0d", a, b), acc, a * b);
    repeat (5) begin
      @(negedge Clk);
      chk("hold_done", outs(), V_DONE);
    end
    St = 1'b0;
    @(negedge Clk);
    chk("back_idle", outs(), V_IDLE);
  endtask

  initial begin
    Rst_n  = 1'b0;
    St     = 1'b0;
    mplier = '0;
    mcand  = '0;
    #3;
    chk("rst_outs", outs(), V_IDLE);
    @(negedge Clk);
    chk("rst_held", outs(), V_IDLE);
    Rst_n = 1'b1;
    @(negedge Clk);
    chk("idle_st0", outs(), V_IDLE);

    run_op(4'd5, 4'd3);
    run_op(4'd7, 4'd0);
    run_op(4'd3, 4'd15);
    run_op(4'd9, 4'd10);
    run_op(4'd15, 4'd1);

    // async reset in the middle of BIT
    mplier = 4'd5;
    mcand  = 4'd2;
    St = 1'b1;
    @(negedge Clk);
    chk("mid_load", outs(), V_LOAD);
    @(negedge Clk);
    chk("mid_bit", outs(), V_AD);
    #2 Rst_n = 1'b0;
    #1 chk("rst_async", outs(), V_IDLE);
    St = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b1;
    repeat (2) @(negedge Clk);
    chk("post_rst_idle", outs(), V_IDLE);

    // St high across reset release starts on the first edge
    Rst_n  = 1'b0;
    mplier = '0;
    St = 1'b1;
    @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
    chk("rel_load", outs(), V_LOAD);
    St = 1'b0;
    repeat (2 * N + 4) @(negedge Clk);
    chk("rel_idle", outs(), V_IDLE);

`ifdef MULT_CTRL_ABORT_EN
    mplier = 4'b0010;
    mcand  = 4'd3;
    St = 1'b1;
    @(negedge Clk);
    chk("ab_load", outs(), V_LOAD);
    St = 1'b0;
    @(negedge Clk);
    chk("ab_bit1", outs(), V_SH);
    @(negedge Clk);
    Abort = 1'b1;
    #1 chk("ab_quiet", outs(), 5'b00010);
    @(posedge Clk);
    #1 Abort = 1'b0;
    chk("ab_idle", outs(), V_IDLE);
    repeat (2 * N) begin
      @(negedge Clk);
      chk("ab_nodone", outs(), V_IDLE);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
